// File: rtl/jpeg_pkg.sv
// Shared JPEG datapath definitions: word width, byte-swap helper and the
// output-stage state type used by the stream FIFOs.
package jpeg_pkg;

    localparam int unsigned JPEG_DATA_W = 32;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        VALID = 1'b1
    } jpeg_out_state_e;

    function automatic logic [JPEG_DATA_W-1:0] jpeg_byteswap32(input logic [JPEG_DATA_W-1:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage

// File: rtl/jpeg_stream_fifo_if.sv
// Host-write / decoder-read bundle of the compressed-stream FIFO.
// slave is the FIFO side, master is the host plus decoder side.
interface jpeg_stream_fifo_if
    import jpeg_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 9
);
    logic                    wr_enable;
    logic [JPEG_DATA_W-1:0]  wr_data;
    logic                    byte_swap;
    logic                    wr_full;
    logic                    almost_full;
    logic                    flush;
    logic                    fifo_enable;
    logic [JPEG_DATA_W-1:0]  fifo_data;
    logic                    fifo_read;
    logic [DEPTH_LOG2:0]     level;
    logic                    overflow;
    logic                    underflow;
    logic                    err_clear;

    modport slave (
        input  wr_enable, wr_data, byte_swap, flush, fifo_read, err_clear,
        output wr_full, almost_full, fifo_enable, fifo_data, level, overflow, underflow
    );

    modport master (
        output wr_enable, wr_data, byte_swap, flush, fifo_read, err_clear,
        input  wr_full, almost_full, fifo_enable, fifo_data, level, overflow, underflow
    );

endinterface

// File: rtl/jpeg_fifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
module jpeg_fifo_ram
    import jpeg_pkg::*;
#(
    parameter int unsigned ADDR_W = 9
) (
    input  logic                   clk_i,
    input  logic                   we_i,
    input  logic [ADDR_W-1:0]      waddr_i,
    input  logic [JPEG_DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0]      raddr_i,
    output logic [JPEG_DATA_W-1:0] rdata_o
);

    logic [JPEG_DATA_W-1:0] mem_q [2**ADDR_W];
    logic [JPEG_DATA_W-1:0] rdata_q;

    // Read-during-write to the same address returns the old word.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/jpeg_stream_fifo.sv
// First-word-fall-through FIFO feeding the decoder's DataIn port, with
// optional byte swap on write, fill level, watermark and sticky error flags.
module jpeg_stream_fifo
    import jpeg_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2   = 9,
    parameter int unsigned AFULL_MARGIN = 16
) (
    input  logic                clk,
    input  logic                rst,
    jpeg_stream_fifo_if.slave   bus
);

    localparam int unsigned Depth = 2 ** DEPTH_LOG2;
    localparam int unsigned LvlW  = DEPTH_LOG2 + 1;
    localparam logic [LvlW-1:0] DepthLvl = LvlW'(Depth);
    localparam logic [LvlW-1:0] AfullLvl = LvlW'(Depth - AFULL_MARGIN);

    logic [DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]        level_q, level_d;
    jpeg_out_state_e        state_q, state_d;
    logic                   byp_sel_q, byp_sel_d;
    logic [JPEG_DATA_W-1:0] byp_q, byp_d;
    logic [JPEG_DATA_W-1:0] hold_q;
    logic                   full_q, full_d;
    logic                   afull_q, afull_d;
    logic                   ovf_q, ovf_d;
    logic                   unf_q, unf_d;

    logic                   wr_acc, rd_acc;
    logic                   ovf_evt, unf_evt;
    logic [JPEG_DATA_W-1:0] wr_word;
    logic [JPEG_DATA_W-1:0] ram_rdata;
    logic [JPEG_DATA_W-1:0] out_data;
    logic                   out_valid;

    assign out_valid = (state_q == VALID);
    assign wr_word   = bus.byte_swap ? jpeg_byteswap32(bus.wr_data) : bus.wr_data;
    assign wr_acc    = bus.wr_enable & ~full_q & ~bus.flush;
    assign rd_acc    = bus.fifo_read & out_valid & ~bus.flush;
    assign ovf_evt   = bus.wr_enable & full_q & ~bus.flush;
    assign unf_evt   = bus.fifo_read & ~out_valid & ~bus.flush;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        byp_sel_d = 1'b0;
        byp_d     = byp_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case ({wr_acc, rd_acc})
                2'b10:   level_d = level_q + LvlW'(1);
                2'b01:   level_d = level_q - LvlW'(1);
                default: level_d = level_q;
            endcase
            // The RAM cannot return a word written this cycle, so a new head
            // that is being written right now is presented from a register.
            if (wr_acc && (wr_ptr_q == rd_ptr_d)) begin
                byp_sel_d = 1'b1;
                byp_d     = wr_word;
            end
        end
        full_d  = (level_d == DepthLvl);
        afull_d = (level_d >= AfullLvl);
        ovf_d   = (ovf_q & ~bus.err_clear) | ovf_evt;
        unf_d   = (unf_q & ~bus.err_clear) | unf_evt;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: begin
                if (wr_acc) begin
                    state_d = VALID;
                end
            end
            VALID: begin
                if (bus.flush) begin
                    state_d = EMPTY;
                end else if (rd_acc && !wr_acc && (level_q == LvlW'(1))) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            state_q   <= EMPTY;
            byp_sel_q <= 1'b0;
            byp_q     <= '0;
            hold_q    <= '0;
            full_q    <= 1'b0;
            afull_q   <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            state_q   <= state_d;
            byp_sel_q <= byp_sel_d;
            byp_q     <= byp_d;
            hold_q    <= out_data;
            full_q    <= full_d;
            afull_q   <= afull_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    // Read address follows the next head so the word is ready one cycle later.
    jpeg_fifo_ram #(
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_word),
        .raddr_i (rd_ptr_d),
        .rdata_o (ram_rdata)
    );

    // hold_q keeps the last presented word visible while empty.
    assign out_data = out_valid ? (byp_sel_q ? byp_q : ram_rdata) : hold_q;

    assign bus.fifo_enable = out_valid;
    assign bus.fifo_data   = out_data;
    assign bus.level       = level_q;
    assign bus.wr_full     = full_q;
    assign bus.almost_full = afull_q;
    assign bus.overflow    = ovf_q;
    assign bus.underflow   = unf_q;

endmodule

// File: tb/tb_jpeg_stream_fifo.sv
// Self-checking bench for jpeg_stream_fifo against a queue-based reference.
module tb_jpeg_stream_fifo;

    localparam int unsigned DL    = 9;
    localparam int unsigned DEPTH = 2 ** DL;
    localparam int unsigned AFM   = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] mq[$];
    logic [31:0] last_data = '0;
    bit          m_ovf = 1'b0;
    bit          m_unf = 1'b0;

    jpeg_stream_fifo_if #(.DEPTH_LOG2(DL)) bus ();

    jpeg_stream_fifo #(
        .DEPTH_LOG2   (DL),
        .AFULL_MARGIN (AFM)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] swap_ref(input logic [31:0] d);
        return {<<8{d}};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] exp_data;
        exp_data = (mq.size() > 0) ? mq[0] : last_data;
        chk({tag, ".enable"},    32'(bus.fifo_enable), 32'(mq.size() > 0));
        chk({tag, ".data"},      bus.fifo_data, exp_data);
        chk({tag, ".level"},     32'(bus.level), 32'(mq.size()));
        chk({tag, ".full"},      32'(bus.wr_full), 32'(mq.size() == DEPTH));
        chk({tag, ".afull"},     32'(bus.almost_full), 32'(mq.size() >= DEPTH - AFM));
        chk({tag, ".overflow"},  32'(bus.overflow), 32'(m_ovf));
        chk({tag, ".underflow"}, 32'(bus.underflow), 32'(m_unf));
    endtask

    task automatic idle();
        bus.wr_enable = 1'b0;
        bus.wr_data   = '0;
        bus.byte_swap = 1'b0;
        bus.flush     = 1'b0;
        bus.fifo_read = 1'b0;
        bus.err_clear = 1'b0;
    endtask

    // One clock with the currently driven inputs; model advances, then compare.
    task automatic cycle(input string tag);
        bit          full, wacc, racc, oe, ue;
        logic [31:0] word;
        full = (mq.size() == DEPTH);
        word = bus.byte_swap ? swap_ref(bus.wr_data) : bus.wr_data;
        @(posedge clk);
        #1;
        if (bus.flush) begin
            mq.delete();
            oe = 1'b0;
            ue = 1'b0;
        end else begin
            wacc = bus.wr_enable && !full;
            racc = bus.fifo_read && (mq.size() > 0);
            oe   = bus.wr_enable && full;
            ue   = bus.fifo_read && (mq.size() == 0);
            if (racc) void'(mq.pop_front());
            if (wacc) mq.push_back(word);
        end
        if (bus.err_clear) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (oe) m_ovf = 1'b1;
        if (ue) m_unf = 1'b1;
        if (mq.size() > 0) last_data = mq[0];
        check_all(tag);
    endtask

    task automatic write_word(input logic [31:0] d, input bit sw, input bit rd);
        bus.wr_enable = 1'b1;
        bus.wr_data   = d;
        bus.byte_swap = sw;
        bus.fifo_read = rd;
    endtask

    task automatic model_reset();
        mq.delete();
        last_data = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    initial begin
        idle();
        #2 rst = 1'b0;
        #1 check_all("reset");
        @(negedge clk);
        rst = 1'b1;

        // Basic write then read
        write_word(32'h1122_3344, 1'b0, 1'b0);
        cycle("basic_wr");
        chk("basic_data", bus.fifo_data, 32'h1122_3344);
        idle();
        bus.fifo_read = 1'b1;
        cycle("basic_rd");
        chk("basic_empty", 32'(bus.fifo_enable), 32'd0);
        idle();

        // Byte swap
        write_word(32'hFFD8_FFE0, 1'b1, 1'b0);
        cycle("swap_wr");
        chk("swap_data", bus.fifo_data, 32'hE0FF_D8FF);
        idle();
        bus.fifo_read = 1'b1;
        cycle("swap_rd");
        idle();

        // Fill to full with 0..511
        for (int i = 0; i < int'(DEPTH); i++) begin
            write_word(32'(i), 1'b0, 1'b0);
            cycle("fill");
        end
        chk("full_level", 32'(bus.level), 32'(DEPTH));
        chk("full_flag", 32'(bus.wr_full), 32'd1);
        write_word(32'hDEAD_BEEF, 1'b0, 1'b0);
        cycle("overflow_wr");
        chk("overflow_flag", 32'(bus.overflow), 32'd1);
        write_word(32'hCAFE_F00D, 1'b0, 1'b1);
        cycle("full_wr_rd");
        chk("full_wr_rd_level", 32'(bus.level), 32'(DEPTH - 1));
        idle();
        bus.fifo_read = 1'b1;
        for (int i = 1; i < int'(DEPTH); i++) begin
            chk("drain_order", bus.fifo_data, 32'(i));
            cycle("drain");
        end
        idle();
        bus.err_clear = 1'b1;
        cycle("clr_ovf");
        idle();

        // Streaming at level 1
        write_word($urandom, 1'($urandom), 1'b0);
        cycle("stream_prime");
        for (int i = 0; i < 1000; i++) begin
            write_word($urandom, 1'($urandom), 1'b1);
            cycle("stream");
        end
        idle();
        bus.fifo_read = 1'b1;
        cycle("stream_drain");
        idle();

        // Underflow and error clear
        bus.fifo_read = 1'b1;
        cycle("underflow");
        chk("underflow_flag", 32'(bus.underflow), 32'd1);
        idle();
        bus.err_clear = 1'b1;
        cycle("err_clear");
        chk("underflow_cleared", 32'(bus.underflow), 32'd0);
        bus.fifo_read = 1'b1;
        cycle("clear_vs_set");
        chk("underflow_set_wins", 32'(bus.underflow), 32'd1);
        idle();

        // Flush with 100 words held
        for (int i = 0; i < 100; i++) begin
            write_word($urandom, 1'($urandom), 1'b0);
            cycle("pre_flush");
        end
        write_word($urandom, 1'b0, 1'b0);
        bus.flush = 1'b1;
        cycle("flush");
        chk("flush_level", 32'(bus.level), 32'd0);
        idle();
        write_word(32'h0BAD_CAFE, 1'b0, 1'b0);
        cycle("post_flush_wr");
        idle();

        // Random mix
        for (int i = 0; i < 2000; i++) begin
            bus.wr_enable = ($urandom_range(99) < 60);
            bus.wr_data   = $urandom;
            bus.byte_swap = 1'($urandom);
            bus.fifo_read = ($urandom_range(99) < 50);
            bus.flush     = ($urandom_range(99) < 2);
            bus.err_clear = ($urandom_range(99) < 5);
            cycle("random");
        end
        idle();

        // Asynchronous reset mid-stream
        for (int i = 0; i < 5; i++) begin
            write_word($urandom, 1'b0, 1'b0);
            cycle("pre_reset");
        end
        idle();
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        @(negedge clk);
        rst = 1'b1;
        write_word(32'h5A5A_A5A5, 1'b0, 1'b0);
        cycle("post_reset_wr");
        idle();
        cycle("post_reset_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
